irq_entry_sequencer: RTL

- CPU-side counterpart of the interrupt controller.
- Samples the controller's 4-bit priority-level request (cpu_irq) at instruction boundaries and compares it with the CPU interrupt mask (SC I-bits).
- On acceptance: runs the acknowledge cycle, pushes the return context to the stack, fetches the 16-bit handler address from the vector table, then hands the new PC/SP/I-level back to the core.
- Owns the bus while busy; the core's fetch/execute is stalled for the whole sequence.

---
 rtl/irq_entry_sequencer.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/irq_entry_sequencer.sv
// irq_entry_sequencer
// CPU-side interrupt entry sequencer. It accepts a prioritised request at an
// instruction boundary, acknowledges it, stacks the return context, fetches
// the 16-bit handler vector and hands the new PC/SP/I-level to the core.
// The bus is owned and the core stalled while busy is high.
//
// Build option:
//   IRQ_CB_PUSH_EN - maximum-mode stacking: CB is pushed first, 4 bytes total.
//                    Left undefined, the PUSH_CB state does not exist and
//                    3 bytes are stacked.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for an unmasked request at an instruction boundary
// ACK       | cpu_iack asserted, vector byte latched from bus_data_in
// PUSH_CB   | push code bank (IRQ_CB_PUSH_EN builds only)
// PUSH_PCH  | push return PC high byte
// PUSH_PCL  | push return PC low byte
// PUSH_SC   | push status register captured at acceptance
// VEC_LO    | read handler address low byte from vector table
// VEC_HI    | read handler address high byte from vector table
// DONE      | one-cycle done pulse; core loads new_pc/new_sp/new_i_level

module irq_entry_sequencer #(
  parameter logic [7:0] STACK_BANK  = 8'h00,
  parameter logic [7:0] VECTOR_BANK = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic [3:0]  cpu_irq,
  input  logic [1:0]  irq_mask,
  input  logic        instr_boundary,
  input  logic [15:0] pc,
  input  logic [7:0]  cb,
  input  logic [7:0]  sc,
  input  logic [15:0] sp,
  input  logic [7:0]  bus_data_in,
  output logic        busy,
  output logic        cpu_iack,
  output logic        bus_read,
  output logic        bus_write,
  output logic [23:0] bus_address_out,
  output logic [7:0]  bus_data_out,
  output logic [15:0] new_pc,
  output logic [15:0] new_sp,
  output logic [1:0]  new_i_level,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_ACK      = 4'd1,
    S_PUSH_PCH = 4'd3,
    S_PUSH_PCL = 4'd4,
    S_PUSH_SC  = 4'd5,
    S_VEC_LO   = 4'd6,
    S_VEC_HI   = 4'd7,
    S_DONE     = 4'd8
`ifdef IRQ_CB_PUSH_EN
    , S_PUSH_CB = 4'd2
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  req_level;
  logic        accept;

  logic [15:0] pc_q;
  logic [7:0]  sc_q;
  logic [15:0] sp_q;
  logic [1:0]  lvl_q;
  logic [7:0]  vec_q;
  logic [15:0] new_pc_q;
  logic [15:0] new_sp_q;
  logic [1:0]  new_lvl_q;

  logic [15:0] sp_dec;
  logic [7:0]  vec_inc;

`ifdef IRQ_CB_PUSH_EN
  logic [7:0]  cb_q;
  logic        unused_inputs;
  assign unused_inputs = cpu_irq[0];
`else
  // CB is only stacked in maximum mode; bit 0 of the request is never a level.
  logic        unused_inputs;
  assign unused_inputs = ^{cb, cpu_irq[0]};
`endif

  // Highest pending level wins; level 0 means no request.
  always_comb begin
    req_level = 2'd0;
    if (cpu_irq[3])      req_level = 2'd3;
    else if (cpu_irq[2]) req_level = 2'd2;
    else if (cpu_irq[1]) req_level = 2'd1;
  end

  // Only strictly higher levels than the current mask interrupt the core.
  assign accept  = instr_boundary && (req_level != 2'd0) && (req_level > irq_mask);

  // Stack pointer is pre-decremented for every push; vector high byte stays in the page.
  assign sp_dec  = sp_q - 16'd1;
  assign vec_inc = vec_q + 8'd1;

  // State register, advancing only on enabled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else if (clk_ce) state <= state_nxt;
  end

  // Next-state sequencing; every state lasts exactly one enabled cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (accept) state_nxt = S_ACK;
`ifdef IRQ_CB_PUSH_EN
      S_ACK:      state_nxt = S_PUSH_CB;
      S_PUSH_CB:  state_nxt = S_PUSH_PCH;
`else
      S_ACK:      state_nxt = S_PUSH_PCH;
`endif
      S_PUSH_PCH: state_nxt = S_PUSH_PCL;
      S_PUSH_PCL: state_nxt = S_PUSH_SC;
      S_PUSH_SC:  state_nxt = S_VEC_LO;
      S_VEC_LO:   state_nxt = S_VEC_HI;
      S_VEC_HI:   state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Context capture, stack pointer tracking and vector assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= 16'h0000;
      sc_q      <= 8'h00;
      sp_q      <= 16'h0000;
      lvl_q     <= 2'd0;
      vec_q     <= 8'h00;
      new_pc_q  <= 16'h0000;
      new_sp_q  <= 16'h0000;
      new_lvl_q <= 2'd0;
`ifdef IRQ_CB_PUSH_EN
      cb_q      <= 8'h00;
`endif
    end else if (clk_ce) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            pc_q  <= pc;
            sc_q  <= sc;
            sp_q  <= sp;
            lvl_q <= req_level;
`ifdef IRQ_CB_PUSH_EN
            cb_q  <= cb;
`endif
          end
        end
        // Vector table entries are word aligned, so bit 0 is dropped.
        S_ACK:      vec_q <= {bus_data_in[7:1], 1'b0};
`ifdef IRQ_CB_PUSH_EN
        S_PUSH_CB:  sp_q <= sp_dec;
`endif
        S_PUSH_PCH: sp_q <= sp_dec;
        S_PUSH_PCL: sp_q <= sp_dec;
        S_PUSH_SC:  sp_q <= sp_dec;
        S_VEC_LO:   new_pc_q[7:0] <= bus_data_in;
        S_VEC_HI: begin
          new_pc_q[15:8] <= bus_data_in;
          new_sp_q       <= sp_q;
          new_lvl_q      <= lvl_q;
        end
        default: ;
      endcase
    end
  end

  // Bus strobes, address and write data decoded from the current state.
  always_comb begin
    busy            = (state != S_IDLE);
    cpu_iack        = 1'b0;
    bus_read        = 1'b0;
    bus_write       = 1'b0;
    bus_address_out = 24'h000000;
    bus_data_out    = 8'h00;
    done            = 1'b0;
    case (state)
      S_ACK: cpu_iack = 1'b1;
`ifdef IRQ_CB_PUSH_EN
      S_PUSH_CB: begin
        bus_write       = 1'b1;
        bus_address_out = {STACK_BANK, sp_dec};
        bus_data_out    = cb_q;
      end
`endif
      S_PUSH_PCH: begin
        bus_write       = 1'b1;
        bus_address_out = {STACK_BANK, sp_dec};
        bus_data_out    = pc_q[15:8];
      end
      S_PUSH_PCL: begin
        bus_write       = 1'b1;
        bus_address_out = {STACK_BANK, sp_dec};
        bus_data_out    = pc_q[7:0];
      end
      S_PUSH_SC: begin
        bus_write       = 1'b1;
        bus_address_out = {STACK_BANK, sp_dec};
        bus_data_out    = sc_q;
      end
      S_VEC_LO: begin
        bus_read        = 1'b1;
        bus_address_out = {VECTOR_BANK, 8'h00, vec_q};
      end
      S_VEC_HI: begin
        bus_read        = 1'b1;
        bus_address_out = {VECTOR_BANK, 8'h00, vec_inc};
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign new_pc      = new_pc_q;
  assign new_sp      = new_sp_q;
  assign new_i_level = new_lvl_q;

endmodule
